// File: rtl/teknofest_prog_pkg.sv
// Shared constants, FSM states and baud divider for the TEKNOFEST
// programming link (transmit and receive sides).
package teknofest_prog_pkg;

   localparam int HDR_LEN = 9;
   localparam logic [8*HDR_LEN-1:0] HDR_STR = "TEKNOFEST";

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_LENGTH,
      S_FETCH,
      S_DATA,
      S_FINISH
   } state_e;

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
      logic [8*HDR_LEN-1:0] s;
      s = HDR_STR << {idx, 3'b000};
      return s[8*HDR_LEN-1 -: 8];
   endfunction

endpackage

// File: rtl/teknofest_uart_tx_byte.sv
// 8N1 byte serializer; ready rises on the last stop-bit cycle so
// consecutive bytes go out with no idle gap.
module teknofest_uart_tx_byte #(
   parameter int DIV = 868
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] byte_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       ser_tx_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] div_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;
   logic          active;
   logic          tick;

   assign tick    = (div_cnt == CW'(DIV - 1));
   assign ready_o = !active || (bit_cnt == 4'd9 && tick);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '1;
         active   <= 1'b0;
         ser_tx_o <= 1'b1;
      end else if (valid_i && ready_o) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= {1'b1, byte_i};
         active   <= 1'b1;
         ser_tx_o <= 1'b0;
      end else if (active) begin
         if (tick) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               active <= 1'b0;
            end else begin
               // bit 8 shifts out the stop bit held in shreg[8]
               ser_tx_o <= shreg[0];
               shreg    <= {1'b1, shreg[8:1]};
               bit_cnt  <= bit_cnt + 4'd1;
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/teknofest_prog_tx.sv
// TEKNOFEST boot-programming stream transmitter: header, length, words.
// Optional abort_i port enabled by TEKNO_PROG_TX_ABORT_EN.
module teknofest_prog_tx
   import teknofest_prog_pkg::*;
#(
   parameter int CPU_CLK   = 100_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int ADDR_W    = 17
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [31:0]       word_count_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [31:0]       rd_data_i,
   output logic              ser_tx_o,
   output logic              busy_o,
   output logic              done_o
`ifdef TEKNO_PROG_TX_ABORT_EN
   ,
   input  logic              abort_i
`endif
);

   localparam int DIV = calc_div(CPU_CLK, BAUD_RATE);

   state_e      state_q, state_d;
   logic [3:0]  byte_idx_q, byte_idx_d;
   logic [31:0] n_q, n_d;
   logic [31:0] idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        fetch_q, fetch_d;
   logic        abort_q, abort_d;
   logic        done_d;
   logic        tx_valid, tx_ready;
   logic [7:0]  tx_data;

   function automatic logic [7:0] msb_byte(input logic [31:0] w,
                                           input logic [1:0] i);
      logic [31:0] t;
      t = w << {i, 3'b000};
      return t[31:24];
   endfunction

   assign rd_addr_o = idx_q[ADDR_W-1:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         byte_idx_q <= '0;
         n_q        <= '0;
         idx_q      <= '0;
         word_q     <= '0;
         fetch_q    <= 1'b0;
         abort_q    <= 1'b0;
         done_o     <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         fetch_q    <= fetch_d;
         abort_q    <= abort_d;
         done_o     <= done_d;
         busy_o     <= (state_d != S_IDLE);
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      n_d        = n_q;
      idx_d      = idx_q;
      word_d     = word_q;
      fetch_d    = 1'b0;
      abort_d    = abort_q;
      done_d     = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      rd_en_o    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // a start coinciding with the done pulse is dropped
            if (start_i && !done_o) begin
               n_d        = word_count_i;
               idx_d      = '0;
               byte_idx_d = '0;
               abort_d    = 1'b0;
               state_d    = S_HEADER;
            end
         end
         S_HEADER: begin
            tx_valid = 1'b1;
            tx_data  = hdr_byte(byte_idx_q);
            if (tx_ready) begin
               if (byte_idx_q == 4'(HDR_LEN - 1)) begin
                  byte_idx_d = '0;
                  state_d    = S_LENGTH;
               end else begin
                  byte_idx_d = byte_idx_q + 4'd1;
               end
            end
         end
         S_LENGTH: begin
            tx_valid = 1'b1;
            tx_data  = msb_byte(n_q, byte_idx_q[1:0]);
            if (tx_ready) begin
               if (byte_idx_q == 4'd3) begin
                  byte_idx_d = '0;
                  state_d    = (n_q == '0) ? S_FINISH : S_FETCH;
               end else begin
                  byte_idx_d = byte_idx_q + 4'd1;
               end
            end
         end
         S_FETCH: begin
            if (!fetch_q) begin
               rd_en_o = 1'b1;
               fetch_d = 1'b1;
            end else begin
               word_d     = rd_data_i;
               byte_idx_d = '0;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            tx_valid = 1'b1;
            tx_data  = msb_byte(word_q, byte_idx_q[1:0]);
            if (tx_ready) begin
               if (byte_idx_q == 4'd3) begin
                  byte_idx_d = '0;
                  idx_d      = idx_q + 32'd1;
                  state_d    = (idx_q + 32'd1 == n_q) ? S_FINISH : S_FETCH;
               end else begin
                  byte_idx_d = byte_idx_q + 4'd1;
               end
            end
         end
         S_FINISH: begin
            if (tx_ready) begin
               state_d = S_IDLE;
               done_d  = !abort_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef TEKNO_PROG_TX_ABORT_EN
      // drain the byte in flight through FINISH, then drop silently
      if (abort_i && state_q != S_IDLE) begin
         abort_d = 1'b1;
         done_d  = 1'b0;
         if (state_q != S_FINISH)
            state_d = S_FINISH;
      end
`endif
   end

   teknofest_uart_tx_byte #(
      .DIV (DIV)
   ) u_ser (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .byte_i   (tx_data),
      .valid_i  (tx_valid),
      .ready_o  (tx_ready),
      .ser_tx_o (ser_tx_o)
   );

endmodule
